frame_scan_reader: RTL
======================

FRAME_SCAN_READER -- requirements
Module: frame_scan_reader

Parameters
REQ-001 SHALL have parameter H_ACTIVE, default 100, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 100, lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 1, buffer address of pixel 0.
REQ-004 SHALL have parameter ADDR_W, default 20, buffer address width.

Interface
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse, begin scanning.
REQ-008 cont  in  1  1 = restart automatically after each frame.
REQ-009 full0, full1  in  1 each  buffer 0/1 holds a complete frame.
REQ-010 re0, re1  out  1 each  read enable to buffer 0/1.
REQ-011 addr  out  ADDR_W  read address shared by both buffers.
REQ-012 r0,g0,b0 / r1,g1,b1  in  8 each  buffer read data, valid the cycle after re.
REQ-013 pix_valid  out  1; pix_ready  in  1  output stream handshake.
REQ-014 pix_data  out  24  {R[23:16], G[15:8], B[7:0]}.
REQ-015 pix_sof, pix_eof, pix_sol, pix_eol  out  1 each  frame/line markers, qualified by pix_valid.
REQ-016 buf_sel  out  1  buffer currently or next scanned.
REQ-017 busy  out  1; done  out  1  done = one-cycle end-of-frame pulse.

Function
REQ-018 FSM states IDLE, WAIT, READ, DRAIN, DONE; busy=1 in every state except IDLE.
REQ-019 IDLE: start=1 -> WAIT; start ignored in every other state.
REQ-020 WAIT: selected full (full0 if buf_sel=0, else full1) =1 -> READ; otherwise stay.
REQ-021 READ: re<buf_sel> asserted on each issue cycle, addr = BASE_ADDR + issue_count, issue_count 0..H_ACTIVE*V_ACTIVE-1; re of the unselected buffer SHALL remain 0.
REQ-022 Issue allowed when fifo_count + inflight - pop < 2 (pop = pix_valid & pix_ready); inflight = re asserted previous cycle.
REQ-023 Returned data SHALL be muxed by the buf_sel value registered at issue and written to a 2-entry FIFO at the end of the cycle after re.
REQ-024 Latency: first re in the first READ cycle; first pix_valid exactly 2 cycles later with pix_ready=1.
REQ-025 Throughput: with pix_ready held 1, one pixel per cycle, no bubbles after the first.
REQ-026 After the last address is issued -> DRAIN; re=0 throughout DRAIN.
REQ-027 DRAIN: fifo empty and inflight=0 -> DONE.
REQ-028 DONE (one cycle): done=1, buf_sel toggles; cont=1 -> WAIT, else IDLE.
REQ-029 pix_valid=1 with pix_ready=0: pix_data and markers SHALL hold stable; no FIFO overflow, no lost or duplicated pixel.
REQ-030 Output counters x (0..H_ACTIVE-1), y (0..V_ACTIVE-1) advance on pop; x wraps to 0 and y increments at x=H_ACTIVE-1.
REQ-031 pix_sol = (x==0); pix_eol = (x==H_ACTIVE-1); pix_sof = (x==0 & y==0); pix_eof = (x==H_ACTIVE-1 & y==V_ACTIVE-1).
REQ-032 Deassertion of the selected full during READ/DRAIN SHALL not abort the frame.

Reset
REQ-033 reset=1 at any clock edge: state=IDLE, re0=re1=0, addr=0, pix_valid=0, pix_data=0, all markers 0, buf_sel=0, busy=0, done=0, FIFO flushed, counters 0.
REQ-034 Reset mid-frame: data returning the cycle after reset SHALL be discarded.

Verification
REQ-035 H=4,V=2, full0=1, start, pix_ready=1 -> addr 1..8 on consecutive cycles, 8 pixels back-to-back, sof on pixel 0, eol on 3 and 7, eof on 7, done pulse, buf_sel=1, IDLE.
REQ-036 pix_ready random 50% -> pixel sequence identical to memory contents in order, data held stable while stalled, re never issued with fifo_count + inflight - pop = 2.
REQ-037 cont=1, full1=0 after frame 0 -> stays WAIT with re1=0; full1=1 -> frame scanned with re1 only, re0=0 throughout.
REQ-038 reset asserted at pixel 5 of 8 -> next cycle all outputs at reset values; new start rescans from addr 1, sof on first pixel.
REQ-039 start pulsed during READ -> ignored, exactly H_ACTIVE*V_ACTIVE pixels and one done pulse.

Source files
------------

// File: rtl/frame_scan_reader.sv
// Double-buffered frame scanner: issues reads to the selected buffer, collects returned pixels in
// a 2-entry FIFO and emits a valid/ready pixel stream with frame and line markers.
module frame_scan_reader #(
    parameter int H_ACTIVE  = 100,
    parameter int V_ACTIVE  = 100,
    parameter int BASE_ADDR = 1,
    parameter int ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic              full0,
    input  logic              full1,
    output logic              re0,
    output logic              re1,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        r0,
    input  logic [7:0]        g0,
    input  logic [7:0]        b0,
    input  logic [7:0]        r1,
    input  logic [7:0]        g1,
    input  logic [7:0]        b1,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_eof,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              buf_sel,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int XW    = $clog2(H_ACTIVE + 1);
    localparam int YW    = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] LAST_ISSUE = CW'(TOTAL - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {StIdle, StWait, StRead, StDrain, StDone} state_t;

    state_t          state;
    logic [CW-1:0]   issue_count;
    logic            inflight;
    logic            sel_at_issue;
    logic [23:0]     fifo_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      fifo_count;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            pop;
    logic            issue;
    logic            sel_full;
    logic [2:0]      occupancy;
    logic [23:0]     rd_data;

    always_comb begin
        pix_valid = (fifo_count != 2'd0);
        pop       = pix_valid & pix_ready;
        // Slots already promised: stored entries plus the read in flight, minus the one leaving now.
        occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue     = (state == StRead) && (occupancy < 3'd2);
        re0       = issue & ~buf_sel;
        re1       = issue & buf_sel;
        addr      = (state == StRead) ? ADDR_W'(BASE_ADDR) + ADDR_W'(issue_count) : '0;
        sel_full  = buf_sel ? full1 : full0;
        rd_data   = sel_at_issue ? {r1, g1, b1} : {r0, g0, b0};
        pix_data  = fifo_mem[rd_ptr];
        pix_sol   = pix_valid && (x == '0);
        pix_eol   = pix_valid && (x == X_LAST);
        pix_sof   = pix_valid && (x == '0) && (y == '0);
        pix_eof   = pix_valid && (x == X_LAST) && (y == Y_LAST);
        busy      = (state != StIdle);
        done      = (state == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            issue_count  <= '0;
            inflight     <= 1'b0;
            sel_at_issue <= 1'b0;
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_count   <= '0;
            x            <= '0;
            y            <= '0;
            buf_sel      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) sel_at_issue <= buf_sel;
            // Read data is valid the cycle after re, so the in-flight flag is the write strobe.
            if (inflight) begin
                fifo_mem[wr_ptr] <= rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

            if (pop) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            case (state)
                StIdle:  if (start) state <= StWait;
                StWait:  if (sel_full) state <= StRead;
                StRead: begin
                    if (issue) begin
                        if (issue_count == LAST_ISSUE) begin
                            issue_count <= '0;
                            state       <= StDrain;
                        end else begin
                            issue_count <= issue_count + 1'b1;
                        end
                    end
                end
                StDrain: if (fifo_count == 2'd0 && !inflight) state <= StDone;
                StDone: begin
                    buf_sel <= ~buf_sel;
                    state   <= cont ? StWait : StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
